// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, block size, FSM states and S-box mode codes
//
// Purpose : common declarations for the AES round datapath blocks.
// Contents: byte_t, AES_NBYTES, state_e (IDLE/RUN/DONE), MODE_FWD/MODE_INV.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam int AES_NBYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

endpackage

// File: rtl/sbox_dual.sv
// rtl/sbox_dual.sv - dual-mode AES S-box (forward SubBytes / inverse InvSubBytes)
//
// Purpose : single-byte substitution through the FIPS-197 forward table or
//           its inverse, selected per lookup.
// Ports   : data   in  8  byte to substitute
//           inv    in  1  0 = forward S-box, 1 = inverse S-box
//           result out 8  substituted byte
module sbox_dual
  import aes_pkg::*;
(
  input  byte_t data,
  input  logic  inv,
  output byte_t result
);

  // Row r holds entries 16*r .. 16*r+15, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  byte_t fwd_byte;
  byte_t inv_byte;

  assign fwd_byte = FWD[data];
  assign inv_byte = INV[data];
  assign result   = (inv == MODE_INV) ? inv_byte : fwd_byte;

endmodule

// File: rtl/sub_bytes_iter.sv
// rtl/sub_bytes_iter.sv - iterative AES SubBytes/InvSubBytes engine, LANES bytes per cycle
//
// Purpose : substitutes a NBYTES-byte block through LANES shared dual-mode
//           S-boxes over NBYTES/LANES beats, with valid/ready on both sides.
// Ports   : clk, rst_n (async, active low)
//           in_valid/in_ready/in_data/in_inv  block intake (byte 0 = MSB)
//           out_valid/out_ready/out_data      result hand-off
//           busy                              high in RUN or DONE
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int NBYTES = AES_NBYTES,
  parameter int LANES  = 4
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  input  logic                  in_inv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic                  busy
);

  if ((LANES < 1) || (LANES > NBYTES) || ((NBYTES % LANES) != 0)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must divide NBYTES");
  end

  localparam int BEATS = NBYTES / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  state_e              st;
  logic [8*NBYTES-1:0] blk;
  logic                mode;
  logic [CW-1:0]       cnt;

  byte_t               cur      [NBYTES];
  byte_t               lane_in  [LANES];
  byte_t               lane_out [LANES];
  logic [8*NBYTES-1:0] blk_sub;

  // Byte view of the state register: cur[0] is the most significant byte.
  always_comb begin
    for (int i = 0; i < NBYTES; i++) begin
      cur[i] = blk[8*(NBYTES-1-i) +: 8];
    end
  end

  // Lane l works on byte cnt*LANES + l during the current beat.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = cur[(int'(cnt) * LANES + l) % NBYTES];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_dual u_sbox (
      .data   (lane_in[l]),
      .inv    (mode),
      .result (lane_out[l])
    );
  end

  // Write-back: only the beat group selected by cnt takes the S-box image.
  always_comb begin
    blk_sub = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if ((i / LANES) == int'(cnt)) begin
        blk_sub[8*(NBYTES-1-i) +: 8] = lane_out[i % LANES];
      end else begin
        blk_sub[8*(NBYTES-1-i) +: 8] = cur[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      blk  <= '0;
      mode <= MODE_FWD;
      cnt  <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            blk  <= in_data;
            mode <= in_inv;
            cnt  <= '0;
            st   <= RUN;
          end
        end
        RUN: begin
          blk <= blk_sub;
          if (cnt == LAST) begin
            st <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // All outputs come from registers or the state decode only.
  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);
  assign busy      = (st == RUN) || (st == DONE);
  assign out_data  = blk;

endmodule
